// File: rtl/counter_fsm.sv
// Loadable up/down event counter with start/pause/done sequencing,
// a step prescaler and one-shot / wrap / saturate terminal behaviour.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | count holds; enable loads load_val, latches config, starts
//   RUN   | prescaler advances; a step is taken every step_div+1 cycles
//   PAUSE | count and prescaler frozen; pause low returns to RUN
//   DONE  | one-shot run finished; waits for enable low before IDLE
module counter_fsm #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  up_dn,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] step_div,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    output logic [WIDTH-1:0]      count,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  done,
    output logic                  tc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_WRAP = 2'b01;
    localparam logic [1:0] MODE_SAT  = 2'b10;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic                    tc_q, tc_d;
    logic                    up_dn_l_q, up_dn_l_d;
    logic [1:0]              mode_l_q, mode_l_d;
    logic [PRESCALE_W-1:0]   step_div_l_q, step_div_l_d;
    logic [WIDTH-1:0]        limit_l_q, limit_l_d;

    logic                    terminal;

    // Terminal condition for the latched direction; up uses >= so a start
    // value above the limit terminates on the first step.
    always_comb begin
        terminal = 1'b0;
        if (up_dn_l_q) begin
            terminal = (count_q >= limit_l_q);
        end else begin
            terminal = (count_q == '0);
        end
    end

    // Next-state, count, prescaler and terminal-pulse logic.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        presc_d      = presc_q;
        tc_d         = 1'b0;
        up_dn_l_d    = up_dn_l_q;
        mode_l_d     = mode_l_q;
        step_div_l_d = step_div_l_q;
        limit_l_d    = limit_l_q;

        if (clear) begin
            count_d = '0;
            presc_d = '0;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        count_d      = load_val;
                        presc_d      = '0;
                        up_dn_l_d    = up_dn;
                        mode_l_d     = mode;
                        step_div_l_d = step_div;
                        limit_l_d    = limit;
                        state_d      = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == step_div_l_q) begin
                        presc_d = '0;
                        if (!terminal) begin
                            count_d = up_dn_l_q ? (count_q + CNT_ONE)
                                                : (count_q - CNT_ONE);
                        end else begin
                            tc_d = 1'b1;
                            if (mode_l_q == MODE_WRAP) begin
                                count_d = up_dn_l_q ? '0 : limit_l_q;
                            end else if (mode_l_q == MODE_SAT) begin
                                count_d = count_q;
                            end else begin
                                // one-shot, and the reserved mode 11
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PRE_ONE;
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // A level-high enable must not restart the counter.
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and latched configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            presc_q      <= '0;
            tc_q         <= 1'b0;
            up_dn_l_q    <= 1'b0;
            mode_l_q     <= '0;
            step_div_l_q <= '0;
            limit_l_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            tc_q         <= tc_d;
            up_dn_l_q    <= up_dn_l_d;
            mode_l_q     <= mode_l_d;
            step_div_l_q <= step_div_l_d;
            limit_l_q    <= limit_l_d;
        end
    end

    // Status outputs decoded purely from registered state.
    always_comb begin
        count = count_q;
        state = state_q;
        tc    = tc_q;
        busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        done  = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_counter_fsm.sv
// Directed testbench for counter_fsm with hand-computed expectations.
module tb_counter_fsm;

    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 4;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_RUN   = 32'd1;
    localparam logic [31:0] S_PAUSE = 32'd2;
    localparam logic [31:0] S_DONE  = 32'd3;

    logic                  clk;
    logic                  rst;
    logic                  clear;
    logic                  enable;
    logic                  pause;
    logic                  up_dn;
    logic [1:0]            mode;
    logic [PRESCALE_W-1:0] step_div;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      limit;
    logic [WIDTH-1:0]      count;
    logic [1:0]            state;
    logic                  busy;
    logic                  done;
    logic                  tc;

    int n_checks = 0;
    int n_errors = 0;

    counter_fsm #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .enable   (enable),
        .pause    (pause),
        .up_dn    (up_dn),
        .mode     (mode),
        .step_div (step_div),
        .load_val (load_val),
        .limit    (limit),
        .count    (count),
        .state    (state),
        .busy     (busy),
        .done     (done),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic ud, input logic [1:0] md, input int sd,
                         input int lv, input int lim);
        up_dn    = ud;
        mode     = md;
        step_div = PRESCALE_W'(sd);
        load_val = WIDTH'(lv);
        limit    = WIDTH'(lim);
        enable   = 1'b1;
        tick();
    endtask

    int wrap_seq [10] = '{2, 1, 0, 5, 4, 3, 2, 1, 0, 5};

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b0; pause = 1'b0;
        up_dn = 1'b0; mode = 2'b00; step_div = '0; load_val = '0; limit = '0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_state", 32'(state), S_IDLE);
        chk("rst_flags", {29'd0, busy, done, tc}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_hold", 32'(state), S_IDLE);

        // One-shot up, 250..255, enable held high through DONE
        start(1'b1, 2'b00, 0, 250, 255);
        chk("os_load", 32'(count), 32'd250);
        chk("os_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("os_count", 32'(count), 32'(250 + k));
            chk("os_tc_low", 32'(tc), 32'd0);
        end
        tick();
        chk("os_tc", 32'(tc), 32'd1);
        chk("os_state_done", 32'(state), S_DONE);
        chk("os_done", 32'(done), 32'd1);
        chk("os_hold", 32'(count), 32'd255);
        tick();
        chk("os_tc_once", 32'(tc), 32'd0);
        chk("os_no_restart", 32'(state), S_DONE);
        chk("os_hold2", 32'(count), 32'd255);
        enable = 1'b0;
        tick();
        chk("os_to_idle", 32'(state), S_IDLE);
        chk("os_done_low", 32'(done), 32'd0);

        // Wrap down, load 2, limit 5
        start(1'b0, 2'b01, 0, 2, 5);
        enable = 1'b0;
        chk("wr_count0", 32'(count), 32'd2);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("wr_count", 32'(count), 32'(wrap_seq[i]));
            chk("wr_tc", 32'(tc), (wrap_seq[i-1] == 0) ? 32'd1 : 32'd0);
            chk("wr_state", 32'(state), S_RUN);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("wr_clear_state", 32'(state), S_IDLE);
        chk("wr_clear_count", 32'(count), 32'd0);

        // Prescaler 3 with a pause window of 5 cycles (entry cycle included)
        start(1'b1, 2'b00, 3, 0, 10);
        enable = 1'b0;
        chk("ps_load", 32'(count), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("ps_wait", 32'(count), 32'd0);
        end
        tick();
        chk("ps_step1", 32'(count), 32'd1);
        tick(); tick();
        chk("ps_pre2", 32'(count), 32'd1);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ps_paused_state", 32'(state), S_PAUSE);
            chk("ps_paused_count", 32'(count), 32'd1);
        end
        pause = 1'b0;
        tick();
        chk("ps_resume_state", 32'(state), S_RUN);
        chk("ps_resume_count", 32'(count), 32'd1);
        tick();
        chk("ps_not_yet", 32'(count), 32'd1);
        tick();
        chk("ps_step2", 32'(count), 32'd2);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("ps_wait2", 32'(count), 32'd2);
        end
        tick();
        chk("ps_step3", 32'(count), 32'd3);
        pause = 1'b1;
        tick();
        chk("ps_pause2", 32'(state), S_PAUSE);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        pause = 1'b0;
        chk("ps_clear_state", 32'(state), S_IDLE);
        chk("ps_clear_count", 32'(count), 32'd0);

        // Saturate up, load above limit: every step terminal
        start(1'b1, 2'b10, 0, 200, 100);
        enable = 1'b0;
        chk("sat_load", 32'(count), 32'd200);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sat_tc", 32'(tc), 32'd1);
            chk("sat_count", 32'(count), 32'd200);
            chk("sat_state", 32'(state), S_RUN);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Reserved mode 11 behaves as one-shot
        start(1'b1, 2'b11, 0, 254, 255);
        enable = 1'b0;
        tick();
        chk("m3_count", 32'(count), 32'd255);
        tick();
        chk("m3_done", 32'(state), S_DONE);
        chk("m3_tc", 32'(tc), 32'd1);
        tick();
        chk("m3_idle", 32'(state), S_IDLE);

        // clear beats enable in IDLE
        clear = 1'b1;
        enable = 1'b1;
        load_val = 8'd99;
        tick();
        clear = 1'b0;
        enable = 1'b0;
        chk("ce_state", 32'(state), S_IDLE);
        chk("ce_count", 32'(count), 32'd0);

        // Async reset mid-cycle during RUN with count 37
        start(1'b1, 2'b00, 15, 37, 200);
        enable = 1'b0;
        chk("ar_run", 32'(state), S_RUN);
        chk("ar_count", 32'(count), 32'd37);
        #4;
        rst = 1'b1;
        #1;
        chk("ar_count0", 32'(count), 32'd0);
        chk("ar_state", 32'(state), S_IDLE);
        chk("ar_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_stay_idle", 32'(state), S_IDLE);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/counter_fsm.md
# counter_fsm

Parametrised, loadable up/down event counter with a start/pause/done state machine, programmable step prescaler and three terminal-count modes: one-shot, wrap and saturate. It replaces fixed 8-bit counting registers wherever the design needs a timed or bounded count with a status handshake. Typical users are control FSMs and timers.

## Interface
- WIDTH, 8: counter width in bits; must be at least 2.
- PRESCALE_W, 4: width of the step-divider input.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous clear; highest priority after rst.
- enable  in  1  level; in IDLE, starts a count run.
- pause  in  1  level; freezes count and prescaler while RUN/PAUSE.
- up_dn  in  1  1 = count up, 0 = count down. Latched at start.
- mode  in  2  00 one-shot, 01 wrap, 10 saturate, 11 treated as one-shot. Latched at start.
- step_div  in  PRESCALE_W  one step per (step_div+1) RUN cycles. Latched at start.
- load_val  in  WIDTH  start value, loaded at start.
- limit  in  WIDTH  upper bound. Latched at start.
- count  out  WIDTH  current count, registered.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.
- tc  out  1  one-cycle pulse on every terminal step, registered.

## Operation
- Reset (async) forces the following values, holding them while rst is high:
  - count = 0, state = IDLE, tc = 0, done = 0, busy = 0;
  - prescaler = 0;
  - latched config = 0.
- clear=1, any state: next edge gives count = 0, prescaler = 0, tc = 0, state = IDLE.
- IDLE: count holds.
  - enable=1: count ← load_val, prescaler ← 0, latch up_dn/mode/step_div/limit, go to RUN.
- RUN:
  - pause=1: go to PAUSE. No step and no prescaler advance that cycle.
  - Otherwise, prescaler == step_div_l: take a step and set prescaler ← 0.
  - Otherwise: prescaler ← prescaler + 1.
- Terminal condition:
  - up: count ≥ limit_l;
  - down: count == 0.
- Step when the terminal condition is false: count ← count ± 1.
- Step when the terminal condition is true is a terminal step. tc=1 for that cycle only, then by mode:
  - one-shot: count holds, go to DONE;
  - wrap: count ← (up ? 0 : limit_l), stay RUN;
  - saturate: count holds, stay RUN; tc fires on each subsequent step.
- PAUSE: count and prescaler hold. pause=0 returns to RUN next edge, and the prescaler resumes from its held value.
- DONE: count holds.
  - enable=0: go to IDLE.
  - enable held high: stay DONE, so a level enable causes no auto-restart.
- Arithmetic is modulo 2^WIDTH. A load_val above limit_l when counting up is terminal on the first step. limit=0 when counting up makes every step terminal.
- Priority: rst > clear > pause > step.
- enable is ignored outside IDLE/DONE.
- Config inputs are ignored after start.

## Timing
- Start: enable sampled high in IDLE at edge N gives count = load_val and state = RUN after edge N.
- First step lands at edge N+step_div+1, then one step every step_div+1 cycles of RUN.
- Pause: each cycle spent in PAUSE delays all later steps by exactly one cycle. The pause-entry cycle counts as a PAUSE cycle.
- tc and done (one-shot) assert after the terminal-step edge. tc lasts exactly one cycle. done stays high until leaving DONE.
- busy/done/state are decoded from the registered state. They are valid the cycle after a transition, with no combinational path from inputs.
- Latency, enable to DONE in one-shot: (steps to terminal + 1) × (step_div+1) cycles.

## Test plan
- WIDTH=8, one-shot, up, load 250, limit 255, step_div 0, enable at edge N:
  - count is 250..255 at N..N+5;
  - tc=1 and state DONE after N+6;
  - count stays 255;
  - done drops one cycle after enable goes low.
- Wrap, down, load 2, limit 5, step_div 0:
  - count sequence 2,1,0,5,4,3,2,1,0,5;
  - tc pulses once per wrap, only on each 0→5 step.
- Prescaler plus pause, step_div 3, load 0, limit 10, up:
  - steps every 4 cycles;
  - a 5-cycle pause after 2 prescaler ticks delays the next step by exactly 5 cycles;
  - count is unchanged during the pause.
- Saturate, up, load 200, limit 100:
  - the first step is terminal;
  - tc fires on every step;
  - count stays 200 and state stays RUN.
- clear and enable both high in IDLE: state stays IDLE and count = 0. clear during PAUSE gives IDLE with count 0 on the next edge.
- Assert rst asynchronously mid-cycle in RUN with count 37: count = 0 and state = IDLE immediately, before the next edge. After release, state stays IDLE until enable.
